// File: rtl/y86_pkg.sv
// Y86-64 encodings shared by the write-back, decode and forwarding logic.
package y86_pkg;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam int NREGS = 15;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } wb_state_e;

    // Stat codes above INS are not architectural; they retire as INS.
    function automatic logic [2:0] stat_norm(input logic [2:0] s);
        return (s > SINS) ? SINS : s;
    endfunction

endpackage

// File: rtl/wb_status_fsm.sv
// Run/halt tracking, final status latch and commit-enable decode for write-back.
//   state     | meaning
//   ST_RUN    | retiring instructions; AOK commits, any fault/halt stops
//   ST_HALTED | stopped; W inputs ignored until reset
module wb_status_fsm
    import y86_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] W_stat,
    input  logic [3:0] W_icode,
    input  logic [3:0] W_dstE,
    input  logic [3:0] W_dstM,
    input  logic       W_Cnd,
    output logic [2:0] Stat,
    output logic       halted,
    output logic       wr_e_en,
    output logic       wr_m_en,
    output logic       cnt_en
);

    wb_state_e  state_q, state_d;
    logic [2:0] stat_q, stat_d;
    logic [2:0] stat_eff;
    logic       commit;

    assign stat_eff = stat_norm(W_stat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            stat_q  <= SAOK;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        commit  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (stat_eff == SAOK) begin
                    commit = 1'b1;
                end else if (stat_eff != SBUB) begin
                    state_d = ST_HALTED;
                    stat_d  = stat_eff;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // A cmov whose condition failed still retires but leaves its destination alone.
    assign wr_e_en = commit && (W_dstE != RNONE) && !((W_icode == ICMOVXX) && !W_Cnd);
    assign wr_m_en = commit && (W_dstM != RNONE);
    assign cnt_en  = commit && (W_icode != INOP);

    assign Stat   = stat_q;
    assign halted = (state_q == ST_HALTED);

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 program register file on the write-back side: commits W results,
// serves the decode read ports and counts retired instructions.
module wb_regfile
    import y86_pkg::*;
#(
    parameter int          CNT_W         = 32,
    parameter logic [63:0] RSP_INIT      = 64'h0,
    parameter bit          WRITE_THROUGH = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valE,
    input  logic [63:0]      W_valM,
    input  logic [3:0]       W_dstE,
    input  logic [3:0]       W_dstM,
    input  logic             W_Cnd,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [2:0]       Stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired_count,
    input  logic [3:0]       dbg_addr,
    output logic [63:0]      dbg_data
);

    logic [63:0]      regs [NREGS];
    logic [CNT_W-1:0] cnt_q;
    logic             wr_e_en, wr_m_en, cnt_en;

    wb_status_fsm u_status (
        .clk     (clk),
        .rst_n   (rst_n),
        .W_stat  (W_stat),
        .W_icode (W_icode),
        .W_dstE  (W_dstE),
        .W_dstM  (W_dstM),
        .W_Cnd   (W_Cnd),
        .Stat    (Stat),
        .halted  (halted),
        .wr_e_en (wr_e_en),
        .wr_m_en (wr_m_en),
        .cnt_en  (cnt_en)
    );

    // M is written last so it wins when both ports target the same id (popq %rsp).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == int'(RRSP)) ? RSP_INIT : 64'h0;
            end
        end else begin
            if (wr_e_en) regs[W_dstE] <= W_valE;
            if (wr_m_en) regs[W_dstM] <= W_valM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    function automatic logic [63:0] rd_port(input logic [3:0] addr, input logic bypass);
        logic [63:0] v;
        v = 64'h0;
        if (addr != RNONE) v = regs[addr];
        if (bypass && WRITE_THROUGH) begin
            if (wr_m_en && (addr == W_dstM))      v = W_valM;
            else if (wr_e_en && (addr == W_dstE)) v = W_valE;
        end
        return v;
    endfunction

    assign d_rvalA       = rd_port(d_srcA, 1'b1);
    assign d_rvalB       = rd_port(d_srcB, 1'b1);
    assign dbg_data      = rd_port(dbg_addr, 1'b0);
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a write-through/4-bit-counter instance and a stored-read
// instance share stimulus and are compared each cycle against a behavioural model.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic        W_Cnd;
    logic [3:0]  d_srcA, d_srcB, dbg_addr;

    logic [63:0] rvalA0, rvalB0, dbg0, rvalA1, rvalB1, dbg1;
    logic [2:0]  stat0, stat1;
    logic        halted0, halted1;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    wb_regfile #(.CNT_W(32), .RSP_INIT(64'h200), .WRITE_THROUGH(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .W_stat(W_stat), .W_icode(W_icode),
        .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_Cnd(W_Cnd), .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(rvalA0),
        .d_rvalB(rvalB0), .Stat(stat0), .halted(halted0), .retired_count(cnt0),
        .dbg_addr(dbg_addr), .dbg_data(dbg0)
    );

    wb_regfile #(.CNT_W(4), .RSP_INIT(64'h200), .WRITE_THROUGH(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .W_stat(W_stat), .W_icode(W_icode),
        .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_Cnd(W_Cnd), .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(rvalA1),
        .d_rvalB(rvalB1), .Stat(stat1), .halted(halted1), .retired_count(cnt1),
        .dbg_addr(dbg_addr), .dbg_data(dbg1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [63:0] m_regs [16];
    logic [2:0]  m_stat;
    logic        m_halted;
    int unsigned m_cnt;

    function automatic logic [2:0] eff_stat();
        return (W_stat > 3'd4) ? 3'd4 : W_stat;
    endfunction

    function automatic logic commit_now();
        return rst_n && !m_halted && (eff_stat() == 3'd1);
    endfunction

    function automatic logic we_e();
        return commit_now() && (W_dstE != 4'hF) && !(W_icode == 4'd2 && !W_Cnd);
    endfunction

    function automatic logic we_m();
        return commit_now() && (W_dstM != 4'hF);
    endfunction

    function automatic logic [63:0] exp_read(input logic [3:0] a, input logic wt);
        if (a == 4'hF) return 64'h0;
        if (wt && we_m() && W_dstM == a) return W_valM;
        if (wt && we_e() && W_dstE == a) return W_valE;
        return m_regs[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_regs[i] <= (i == 4) ? 64'h200 : 64'h0;
            m_stat   <= 3'd1;
            m_halted <= 1'b0;
            m_cnt    <= 0;
        end else if (!m_halted) begin
            if (eff_stat() == 3'd1) begin
                if (we_e()) m_regs[W_dstE] <= W_valE;
                if (we_m()) m_regs[W_dstM] <= W_valM;
                if (W_icode != 4'd1) m_cnt <= m_cnt + 1;
            end else if (eff_stat() != 3'd0) begin
                m_halted <= 1'b1;
                m_stat   <= eff_stat();
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("rvalA_wt0", rvalA0, exp_read(d_srcA, 1'b0));
            chk("rvalB_wt0", rvalB0, exp_read(d_srcB, 1'b0));
            chk("rvalA_wt1", rvalA1, exp_read(d_srcA, 1'b1));
            chk("rvalB_wt1", rvalB1, exp_read(d_srcB, 1'b1));
            chk("dbg_wt0", dbg0, exp_read(dbg_addr, 1'b0));
            chk("dbg_wt1", dbg1, exp_read(dbg_addr, 1'b0));
            chk("stat0", 64'(stat0), 64'(m_stat));
            chk("stat1", 64'(stat1), 64'(m_stat));
            chk("halted0", 64'(halted0), 64'(m_halted));
            chk("halted1", 64'(halted1), 64'(m_halted));
            chk("cnt0", 64'(cnt0), 64'(m_cnt));
            chk("cnt1", 64'(cnt1), (m_cnt > 15) ? 64'd15 : 64'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [2:0] s, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm,
                         input logic c);
        W_stat = s; W_icode = ic; W_valE = ve; W_valM = vm;
        W_dstE = de; W_dstM = dm; W_Cnd = c;
    endtask

    task automatic idle();
        drive(3'd0, 4'd1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dbg(input string name, input logic [3:0] a, input logic [63:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg0, exp);
        chk(name, dbg1, exp);
    endtask

    task automatic chk_status(input logic [2:0] s, input logic h, input int unsigned c);
        chk("lit_stat", 64'(stat0), 64'(s));
        chk("lit_halted", 64'(halted0), 64'(h));
        chk("lit_cnt0", 64'(cnt0), 64'(c));
        chk("lit_cnt1", 64'(cnt1), (c > 15) ? 64'd15 : 64'(c));
    endtask

    logic [63:0]  saved_rax;
    int unsigned  saved_cnt;

    initial begin
        rst_n = 1'b0;
        idle();
        d_srcA = 4'h0; d_srcB = 4'h0; dbg_addr = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            chk_dbg("reset_reg", 4'(i), (i == 4) ? 64'h200 : 64'h0);
        chk_status(3'd1, 1'b0, 0);
        step();

        drive(3'd1, 4'd5, 64'h1F8, 64'hDEAD, 4'd4, 4'd3, 1'b0);
        step(); idle();
        chk_dbg("dual_rsp", 4'd4, 64'h1F8);
        chk_dbg("dual_rbx", 4'd3, 64'hDEAD);
        chk_status(3'd1, 1'b0, 1);

        drive(3'd1, 4'd11, 64'h8, 64'h55, 4'd4, 4'd4, 1'b0);
        step(); idle();
        chk_dbg("popq_rsp", 4'd4, 64'h55);

        drive(3'd1, 4'd2, 64'h7, 64'h0, 4'd1, 4'hF, 1'b0);
        step(); idle();
        chk_dbg("cmov_nt", 4'd1, 64'h0);
        chk_status(3'd1, 1'b0, 3);

        drive(3'd1, 4'd2, 64'h7, 64'h0, 4'd1, 4'hF, 1'b1);
        step(); idle();
        chk_dbg("cmov_t", 4'd1, 64'h7);

        repeat (5) begin
            drive(3'd1, 4'd1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0);
            step();
        end
        idle();
        chk_status(3'd1, 1'b0, 4);

        d_srcA = 4'd6;
        drive(3'd1, 4'd3, 64'h42, 64'h0, 4'd6, 4'hF, 1'b0);
        #1;
        chk("bypass_wt1", rvalA1, 64'h42);
        chk("bypass_wt0_old", rvalA0, 64'h0);
        step(); idle();
        #1;
        chk("bypass_wt0_new", rvalA0, 64'h42);
        chk_status(3'd1, 1'b0, 5);

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) == 0) ? 3'd0 : 3'd1, 4'($urandom_range(0, 11)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom));
            d_srcA   = 4'($urandom_range(0, 15));
            d_srcB   = 4'($urandom_range(0, 15));
            dbg_addr = 4'($urandom_range(0, 15));
            step();
        end
        idle();
        #1;
        chk("cnt1_saturated", 64'(cnt1), 64'hF);

        saved_rax = m_regs[0];
        saved_cnt = m_cnt;
        drive(3'd3, 4'd6, 64'h9, 64'h0, 4'd0, 4'hF, 1'b0);
        step(); idle();
        chk_dbg("adr_rax", 4'd0, saved_rax);
        chk_status(3'd3, 1'b1, saved_cnt);
        for (int n = 0; n < 5; n++) begin
            drive(3'd1, 4'd6, 64'h1234 + 64'(n), 64'h99, 4'd0, 4'd0, 1'b1);
            step();
        end
        idle();
        chk_dbg("halted_rax", 4'd0, saved_rax);
        chk_status(3'd3, 1'b1, saved_cnt);

        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk_status(3'd1, 1'b0, 0);
        drive(3'd6, 4'd0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0);
        step(); idle();
        chk_status(3'd4, 1'b1, 0);

        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        drive(3'd1, 4'd3, 64'h77, 64'h0, 4'd5, 4'hF, 1'b0);
        @(negedge clk);
        #4 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        chk_dbg("midreset_r5", 4'd5, 64'h0);
        chk_dbg("midreset_rsp", 4'd4, 64'h200);
        chk_status(3'd1, 1'b0, 0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back-side consumer of the W pipeline register in the Y86-64 pipeline.
- Holds the 15-entry 64-bit program register file and commits W_valE and W_valM to W_dstE and W_dstM.
- Serves the two decode read ports and latches the final processor status.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- RSP_INIT, 64'h0, reset value of %rsp (register id 4).
- WRITE_THROUGH, 0, when 1 a read of a register being written this cycle returns the new value; when 0 it returns the stored value.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- W_stat  in  3  status of the instruction in W: 0 idle/bubble, 1 AOK, 2 HLT, 3 ADR, 4 INS.
- W_icode  in  4  icode of the instruction in W.
- W_valE  in  64  ALU result.
- W_valM  in  64  memory read result.
- W_dstE  in  4  E destination register id; 4'hF = RNONE.
- W_dstM  in  4  M destination register id; 4'hF = RNONE.
- W_Cnd  in  1  condition outcome of the instruction in W.
- d_srcA  in  4  decode read address A.
- d_srcB  in  4  decode read address B.
- d_rvalA  out  64  read data A.
- d_rvalB  out  64  read data B.
- Stat  out  3  processor status.
- halted  out  1  processor has stopped.
- retired_count  out  CNT_W  number of committed non-NOP instructions.
- dbg_addr  in  4  debug read address.
- dbg_data  out  64  debug read data.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - All 15 registers cleared to 0, except %rsp, which is set to RSP_INIT.
  - FSM goes to RUN.
  - Stat = 1 (AOK), halted = 0, retired_count = 0.
  - Reset asserted mid-operation overrides any write in flight that cycle.
- FSM, state RUN:
  - W_stat = 0: no write, no count, stay in RUN.
  - W_stat = 1: commit the instruction (see Writes and Counter).
  - W_stat = 2, 3 or 4: no register write, no count. Next state is HALTED. Stat takes the W_stat value and halted = 1, both visible the cycle after the edge.
  - W_stat = 5, 6 or 7: treated as 4 (INS).
- FSM, state HALTED:
  - Sticky until reset.
  - All W inputs are ignored.
  - Stat and halted hold their values; no writes; counter frozen.
- Writes (RUN and W_stat = 1 only):
  - E port writes W_valE to W_dstE when W_dstE != 4'hF.
  - E port is suppressed when W_icode = 2 (cmovXX) and W_Cnd = 0.
  - M port writes W_valM to W_dstM when W_dstM != 4'hF.
  - Both ports may write in the same cycle.
  - When both target the same id, the M port wins (popq %rsp semantics).
- Reads: d_rvalA, d_rvalB and dbg_data are combinational from the array.
  - Address 4'hF reads 0.
  - With WRITE_THROUGH = 1, a read matching an enabled write this cycle returns the write data; the M value has priority over E.
  - dbg_data never uses the bypass.
- Counter:
  - Increments by 1 in RUN when W_stat = 1 and W_icode != 1 (NOP/bubble).
  - Saturates at all-ones.
  - The HLT instruction itself is not counted.
- Latency: a write is visible on the read ports one cycle after the edge. With WRITE_THROUGH = 1 it is also visible in the same cycle as the write.
- No X propagation into state: when W_stat is idle (0) the data inputs are don't-care.

Decomposition:
- Shared package y86_pkg:
  - Stat codes: SAOK, SHLT, SADR, SINS.
  - Icode constants: IHALT through IPOPQ, including INOP = 1 and ICMOVXX = 2.
  - RNONE = 4'hF and RRSP = 4'h4.
  - These constants are shared with the decode and forwarding logic.
- Sub-module: wb_status_fsm holds the RUN/HALTED FSM, the Stat/halted latch and the commit-enable decode.
- The array and counter live in wb_regfile itself.

Test Plan:
- Reset check: with RSP_INIT = 64'h200, release rst_n, then read ids 0–14 and 15. Required: %rsp = 64'h200, all others 0, id 15 = 0, Stat = 1, halted = 0, retired_count = 0.
- Dual write: W_stat = 1, W_icode = 5, W_dstE = 4 with W_valE = 64'h1F8, W_dstM = 3 with W_valM = 64'hDEAD. Required next cycle: %rsp = 64'h1F8, %rbx = 64'hDEAD, retired_count = 1.
- Same-id conflict: W_icode = 11 (popq %rsp), W_dstE = W_dstM = 4, W_valE = 8, W_valM = 64'h55. Required: %rsp = 64'h55.
- cmov gating:
  - W_icode = 2, W_Cnd = 0, W_dstE = 1, W_valE = 7: %rcx unchanged, counter +1.
  - Repeat with W_Cnd = 1: %rcx = 7.
- Halt: W_stat = 3 (ADR) with W_dstE = 0 and W_valE = 9. Required: %rax unchanged, Stat = 3, halted = 1. Subsequent W_stat = 1 writes are ignored, the counter is frozen, and the state persists until rst_n pulses.
- Bubbles and bypass: stream W_stat = 1, W_icode = 1 for 5 cycles → counter unchanged. With WRITE_THROUGH = 1, a same-cycle write of 64'h42 to id 6 with d_srcA = 6 gives d_rvalA = 64'h42 combinationally. With WRITE_THROUGH = 0, d_rvalA shows the old value until the edge.
